// File: rtl/scmp_bus_pkg.sv
// Shared types and widths for the SC/MP bus responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scmp_bus_pkg;

  localparam int SCMP_ADDR_W = 16;
  localparam int SCMP_DATA_W = 8;

  // Status nibble driven by the CPU on the data bus during the address phase.
  typedef struct packed {
    logic h;
    logic d;
    logic i;
    logic r;
  } scmp_status_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    RD_REQ  = 3'd2,
    WR_REQ  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } scmp_resp_state_t;

endpackage

// File: rtl/scmp_addr_latch.sv
// Captures the multiplexed address/status phase whenever ads_n is low.
// Latency: mem_addr/st_flags valid one edge after the ADS sample.
// Backpressure: none; ADS always overwrites the previous capture.
module scmp_addr_latch
  import scmp_bus_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ads_n,
  input  logic [11:0]            addr,
  input  logic [SCMP_DATA_W-1:0] cpu_d_o,
  output logic [SCMP_ADDR_W-1:0] mem_addr,
  output logic [3:0]             st_flags
);

  logic [SCMP_ADDR_W-1:0] r_addr;
  scmp_status_t           r_status;

  // Upper data nibble carries {H,D,I,R}, lower nibble carries A15..A12.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_status <= '0;
    end else if (!ads_n) begin
      r_addr   <= {cpu_d_o[3:0], addr};
      r_status <= scmp_status_t'(cpu_d_o[7:4]);
    end
  end

  assign mem_addr = r_addr;
  assign st_flags = r_status;

endmodule

// File: rtl/scmp_bus_responder.sv
// Memory-side SC/MP bus responder: turns CPU strobes into mem req/ack cycles.
// Latency: request on the edge after the strobe; read data one edge after mem_ack.
// Backpressure: hold is high while a mem request is outstanding; timeout aborts.
module scmp_bus_responder
  import scmp_bus_pkg::*;
#(
  parameter int                     TIMEOUT  = 64,
  parameter logic [SCMP_DATA_W-1:0] ERR_DATA = 8'hFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [11:0]            addr,
  input  logic [SCMP_DATA_W-1:0] cpu_d_o,
  input  logic                   ads_n,
  input  logic                   rd_n,
  input  logic                   wr_n,
  output logic [SCMP_DATA_W-1:0] cpu_d_i,
  output logic                   cpu_d_oe,
  output logic                   hold,
  output logic [3:0]             st_flags,
  output logic [SCMP_ADDR_W-1:0] mem_addr,
  output logic [SCMP_DATA_W-1:0] mem_wdata,
  output logic                   mem_rd_req,
  output logic                   mem_wr_req,
  input  logic [SCMP_DATA_W-1:0] mem_rdata,
  input  logic                   mem_ack,
  output logic                   bus_err
);

  localparam int                CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  scmp_resp_state_t       r_state, w_state;
  logic [CNT_W-1:0]       r_cnt, w_cnt;
  logic                   r_rd_req, w_rd_req;
  logic                   r_wr_req, w_wr_req;
  logic [SCMP_DATA_W-1:0] r_wdata, w_wdata;
  logic [SCMP_DATA_W-1:0] r_rdata, w_rdata;
  logic                   r_oe, w_oe;
  logic                   r_err, w_err;

  scmp_addr_latch u_addr_latch (
    .clk      (clk),
    .rst      (rst),
    .ads_n    (ads_n),
    .addr     (addr),
    .cpu_d_o  (cpu_d_o),
    .mem_addr (mem_addr),
    .st_flags (st_flags)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state;
  end

  // Datapath registers: request lines, timeout counter, data and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_oe     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt;
      r_rd_req <= w_rd_req;
      r_wr_req <= w_wr_req;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
      r_oe     <= w_oe;
      r_err    <= w_err;
    end
  end

  // Next-state and next-register logic; ADS overrides every state and silently
  // abandons any outstanding memory access.
  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_rd_req = r_rd_req;
    w_wr_req = r_wr_req;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    w_oe     = r_oe;
    w_err    = r_err;

    if (!ads_n) begin
      w_state  = ADDR;
      w_rd_req = 1'b0;
      w_wr_req = 1'b0;
      w_oe     = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Strobes without a preceding ADS are ignored.
        end
        ADDR: begin
          if (!rd_n && !wr_n) begin
            w_err   = 1'b1;
            w_state = DONE;
          end else if (!rd_n) begin
            w_state  = RD_REQ;
            w_rd_req = 1'b1;
            w_cnt    = '0;
          end else if (!wr_n) begin
            w_state  = WR_REQ;
            w_wr_req = 1'b1;
            w_wdata  = cpu_d_o;
            w_cnt    = '0;
          end
        end
        RD_REQ: begin
          // A late ack on the final count still counts as a normal completion.
          if (mem_ack) begin
            w_rdata  = mem_rdata;
            w_rd_req = 1'b0;
            w_oe     = 1'b1;
            w_state  = RD_DATA;
          end else if (r_cnt == CNT_MAX) begin
            w_err    = 1'b1;
            w_rd_req = 1'b0;
            w_rdata  = ERR_DATA;
            w_oe     = 1'b1;
            w_state  = RD_DATA;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        WR_REQ: begin
          if (mem_ack) begin
            w_wr_req = 1'b0;
            w_state  = DONE;
          end else if (r_cnt == CNT_MAX) begin
            w_err    = 1'b1;
            w_wr_req = 1'b0;
            w_state  = DONE;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        RD_DATA: begin
          if (rd_n) begin
            w_oe    = 1'b0;
            w_state = IDLE;
          end
        end
        DONE: begin
          if (rd_n && wr_n) w_state = IDLE;
        end
        default: begin
          w_state  = IDLE;
          w_rd_req = 1'b0;
          w_wr_req = 1'b0;
          w_oe     = 1'b0;
        end
      endcase
    end
  end

  assign cpu_d_i    = r_rdata;
  assign cpu_d_oe   = r_oe;
  assign mem_rd_req = r_rd_req;
  assign mem_wr_req = r_wr_req;
  assign mem_wdata  = r_wdata;
  assign bus_err    = r_err;
  // Stretch the CPU cycle for exactly as long as memory owes us a response.
  assign hold       = r_rd_req | r_wr_req;

endmodule

// File: tb/tb_scmp_bus_responder.sv
// Directed bench for scmp_bus_responder with an event scoreboard.
// Stimulus pushes expected request/read-data events; a negedge monitor pops them.
// Direct checks cover reset, hold length, error flag and abort behaviour.
module tb_scmp_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] addr = '0;
  logic [7:0]  cpu_d_o = '0;
  logic        ads_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  cpu_d_i;
  logic        cpu_d_oe;
  logic        hold;
  logic [3:0]  st_flags;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        bus_err;

  int checks = 0;
  int failures = 0;

  localparam logic [1:0] K_RD = 2'd0, K_WR = 2'd1, K_DAT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] a;
    logic [3:0]  f;
    logic [7:0]  d;
    logic        e;
  } ev_t;

  ev_t exp_q[$];

  scmp_bus_responder #(.TIMEOUT(8), .ERR_DATA(8'hFF)) dut (
    .clk(clk), .rst(rst), .addr(addr), .cpu_d_o(cpu_d_o), .ads_n(ads_n),
    .rd_n(rd_n), .wr_n(wr_n), .cpu_d_i(cpu_d_i), .cpu_d_oe(cpu_d_oe),
    .hold(hold), .st_flags(st_flags), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic ev_t mk(input logic [1:0] k, input logic [15:0] a, input logic [3:0] f,
                             input logic [7:0] d, input logic e);
    ev_t v;
    v.kind = k; v.a = a; v.f = f; v.d = d; v.e = e;
    return v;
  endfunction

  // Monitor: every rising request or rising cpu_d_oe is one scoreboard event.
  logic prev_rd = 1'b0, prev_wr = 1'b0, prev_oe = 1'b0;

  task automatic mon_cmp(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected kind=%0d addr=%0h flags=%0h data=%0h err=%0b",
               got.kind, got.a, got.f, got.d, got.e);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        failures++;
        $display("FAIL sb_event actual kind=%0d addr=%0h flags=%0h data=%0h err=%0b required kind=%0d addr=%0h flags=%0h data=%0h err=%0b",
                 got.kind, got.a, got.f, got.d, got.e, want.kind, want.a, want.f, want.d, want.e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd_req === 1'b1 && prev_rd !== 1'b1)
      mon_cmp(mk(K_RD, mem_addr, st_flags, 8'h00, 1'b0));
    if (mem_wr_req === 1'b1 && prev_wr !== 1'b1)
      mon_cmp(mk(K_WR, mem_addr, st_flags, mem_wdata, 1'b0));
    if (cpu_d_oe === 1'b1 && prev_oe !== 1'b1)
      mon_cmp(mk(K_DAT, 16'h0000, 4'h0, cpu_d_i, bus_err));
    if (mem_rd_req === 1'b1 && mem_wr_req === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL both_req actual=11 required=not both");
    end
    prev_rd = mem_rd_req;
    prev_wr = mem_wr_req;
    prev_oe = cpu_d_oe;
  end

  // Address phase: raw bus values plus hand-computed expected latch contents.
  task automatic addr_phase(input logic [11:0] a, input logic [7:0] d,
                            input logic [15:0] exp_a, input logic [3:0] exp_f);
    ads_n = 1'b0; addr = a; cpu_d_o = d; rd_n = 1'b1; wr_n = 1'b1;
    cyc(1);
    ads_n = 1'b1;
    chk("ads_mem_addr", 32'(mem_addr), 32'(exp_a));
    chk("ads_st_flags", 32'(st_flags), 32'(exp_f));
  endtask

  // Read after an address phase; memory acks on the d-th edge after the request.
  task automatic read_body(input logic [15:0] a, input logic [3:0] f, input int d,
                           input logic [7:0] data, input logic e);
    int n;
    rd_n = 1'b0;
    exp_q.push_back(mk(K_RD, a, f, 8'h00, 1'b0));
    exp_q.push_back(mk(K_DAT, 16'h0000, 4'h0, data, e));
    cyc(1);
    n = 0;
    for (int i = 0; i < d; i++) begin
      if (hold === 1'b1) n++;
      if (i == d - 1) begin mem_ack = 1'b1; mem_rdata = data; end
      cyc(1);
    end
    mem_ack = 1'b0;
    chk("rd_hold_cycles", 32'(n), 32'(d));
    chk("rd_hold_after", 32'(hold), 32'd0);
    chk("rd_oe", 32'(cpu_d_oe), 32'd1);
    rd_n = 1'b1;
    cyc(1);
    chk("rd_oe_release", 32'(cpu_d_oe), 32'd0);
  endtask

  task automatic write_body(input logic [15:0] a, input logic [3:0] f, input int d,
                            input logic [7:0] wd);
    int n;
    cpu_d_o = wd;
    wr_n = 1'b0;
    exp_q.push_back(mk(K_WR, a, f, wd, 1'b0));
    cyc(1);
    n = 0;
    for (int i = 0; i < d; i++) begin
      if (hold === 1'b1) n++;
      if (i == d - 1) mem_ack = 1'b1;
      cyc(1);
    end
    mem_ack = 1'b0;
    chk("wr_hold_cycles", 32'(n), 32'(d));
    chk("wr_hold_after", 32'(hold), 32'd0);
    chk("wr_req_after", 32'(mem_wr_req), 32'd0);
    chk("wr_no_oe", 32'(cpu_d_oe), 32'd0);
    wr_n = 1'b1;
    cyc(1);
  endtask

  logic [7:0] fetch_bytes [8] = '{8'h3F, 8'h12, 8'hA5, 8'h00, 8'hFE, 8'h81, 8'h7C, 8'h44};

  initial begin
    int n;
    // Reset
    rst = 1'b1;
    cyc(2);
    chk("rst_outputs", {mem_addr, mem_wdata, cpu_d_i},  32'h0);
    chk("rst_ctrl", {27'd0, cpu_d_oe, hold, mem_rd_req, mem_wr_req, bus_err}, 32'h0);
    chk("rst_flags", 32'(st_flags), 32'h0);
    rst = 1'b0;

    // Strobes and a stray ack in IDLE without ADS do nothing
    rd_n = 1'b0; mem_ack = 1'b1;
    cyc(2);
    chk("idle_no_req", {30'd0, mem_rd_req, hold}, 32'h0);
    chk("idle_no_oe", 32'(cpu_d_oe), 32'd0);
    rd_n = 1'b1; mem_ack = 1'b0;
    cyc(1);

    // Basic read: ack after 3 cycles
    addr_phase(12'h204, 8'h31, 16'h1204, 4'b0011);
    read_body(16'h1204, 4'b0011, 3, 8'hC4, 1'b0);
    chk("rd_cpu_d_i", 32'(cpu_d_i), 32'hC4);

    // Basic write
    addr_phase(12'h020, 8'h00, 16'h0020, 4'h0);
    write_body(16'h0020, 4'h0, 2, 8'h15);
    chk("wr_no_err", 32'(bus_err), 32'd0);

    // Ack arriving on the final timeout count is a normal completion
    addr_phase(12'h777, 8'h5A, 16'hA777, 4'b0101);
    read_body(16'hA777, 4'b0101, 8, 8'h3C, 1'b0);
    chk("ack_at_limit_no_err", 32'(bus_err), 32'd0);

    // Back-to-back program fetch 0001..0008, one-cycle acks
    for (int i = 0; i < 8; i++) begin
      addr_phase(12'(i + 1), 8'h00, 16'(i + 1), 4'h0);
      read_body(16'(i + 1), 4'h0, 1, fetch_bytes[i], 1'b0);
    end
    chk("fetch_no_err", 32'(bus_err), 32'd0);

    // Abort: new ADS while a read is outstanding
    addr_phase(12'h300, 8'h00, 16'h0300, 4'h0);
    rd_n = 1'b0;
    exp_q.push_back(mk(K_RD, 16'h0300, 4'h0, 8'h00, 1'b0));
    cyc(1);
    chk("abort_req_up", 32'(mem_rd_req), 32'd1);
    cyc(1);
    ads_n = 1'b0; rd_n = 1'b1; addr = 12'h450; cpu_d_o = 8'h82;
    cyc(1);
    ads_n = 1'b1;
    chk("abort_req_drop", {30'd0, mem_rd_req, hold}, 32'h0);
    chk("abort_new_addr", 32'(mem_addr), 32'h2450);
    chk("abort_new_flags", 32'(st_flags), 32'b1000);
    chk("abort_no_err", 32'(bus_err), 32'd0);
    read_body(16'h2450, 4'b1000, 2, 8'h5A, 1'b0);

    // Conflicting strobes
    addr_phase(12'h111, 8'h00, 16'h0111, 4'h0);
    rd_n = 1'b0; wr_n = 1'b0;
    cyc(1);
    chk("conflict_err", 32'(bus_err), 32'd1);
    cyc(1);
    chk("conflict_no_req", {29'd0, mem_rd_req, mem_wr_req, hold}, 32'h0);
    rd_n = 1'b1; wr_n = 1'b1;
    cyc(1);

    // Reset in the middle of a write
    addr_phase(12'h0AB, 8'h2C, 16'hC0AB, 4'b0010);
    cpu_d_o = 8'h99; wr_n = 1'b0;
    exp_q.push_back(mk(K_WR, 16'hC0AB, 4'b0010, 8'h99, 1'b0));
    cyc(1);
    chk("midwr_req_up", 32'(mem_wr_req), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("midwr_rst_data", {mem_addr, mem_wdata, cpu_d_i}, 32'h0);
    chk("midwr_rst_ctrl", {23'd0, st_flags, cpu_d_oe, hold, mem_rd_req, mem_wr_req, bus_err}, 32'h0);
    rst = 1'b0; wr_n = 1'b1;
    cyc(1);

    // Timeout on a read: request held 8 cycles, ERR_DATA returned
    addr_phase(12'h555, 8'h40, 16'h0555, 4'b0100);
    rd_n = 1'b0;
    exp_q.push_back(mk(K_RD, 16'h0555, 4'b0100, 8'h00, 1'b0));
    exp_q.push_back(mk(K_DAT, 16'h0000, 4'h0, 8'hFF, 1'b1));
    cyc(1);
    n = 0;
    while (mem_rd_req === 1'b1 && n < 100) begin
      n++;
      cyc(1);
    end
    chk("to_req_cycles", 32'(n), 32'd8);
    chk("to_err", 32'(bus_err), 32'd1);
    chk("to_hold", 32'(hold), 32'd0);
    chk("to_data", 32'(cpu_d_i), 32'hFF);
    chk("to_oe", 32'(cpu_d_oe), 32'd1);
    rd_n = 1'b1;
    cyc(1);

    // Error is sticky across a following good cycle
    addr_phase(12'h010, 8'h00, 16'h0010, 4'h0);
    read_body(16'h0010, 4'h0, 2, 8'h77, 1'b1);
    chk("sticky_err", 32'(bus_err), 32'd1);

    cyc(3);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
